// File: rtl/router_out_arbiter.sv
// router_out_arbiter: round-robin scheduler forwarding whole packets from per-input
// show-ahead FIFOs onto one valid/ready output port.
module router_out_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_PORTS-1:0]            fifo_pop,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy,
  output logic [15:0]                     pkt_cnt
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
  state_t                state_q, state_d;
  logic [NUM_PORTS-1:0]  grant_q, grant_d;
  logic [IW-1:0]         last_q, last_d, pick;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
  logic [DATA_WIDTH-1:0] words [NUM_PORTS];
  logic [DATA_WIDTH-1:0] head;
  logic [IW:0]           sum;
  logic                  found, xfer;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_words
    assign words[i] = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign head    = words[last_q];
  assign grant   = grant_q;
  assign pkt_cnt = pkt_cnt_q;
  // Search starts just past the last winner, so the port that just finished ranks last.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    sum   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      sum = {1'b0, last_q} + (IW+1)'(k);
      sum = (sum >= (IW+1)'(NUM_PORTS)) ? sum - (IW+1)'(NUM_PORTS) : sum;
      if (!found && !fifo_empty[sum[IW-1:0]]) begin
        pick  = sum[IW-1:0];
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IW'(NUM_PORTS - 1);
      rem_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      rem_q     <= rem_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    rem_d     = rem_q;
    pkt_cnt_d = pkt_cnt_q;
    unique case (state_q)
      IDLE: if (found) begin
        state_d = HDR;
        grant_d = NUM_PORTS'(1) << pick;
        last_d  = pick;
      end
      HDR: if (xfer) begin
        state_d = PAYLOAD;
        rem_d   = head[LEN_WIDTH-1:0];
      end
      PAYLOAD: if (xfer) rem_d = rem_q - LEN_WIDTH'(1);
      default: state_d = IDLE;
    endcase
    if (xfer && out_eop) begin
      state_d   = IDLE;
      grant_d   = '0;
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end
  always_comb begin
    busy      = state_q != IDLE;
    out_valid = busy & ~fifo_empty[last_q];
    out_data  = |grant_q ? head : '0;
    out_sop   = state_q == HDR;
    out_eop   = (state_q == HDR)     ? head[LEN_WIDTH-1:0] == '0 :
                (state_q == PAYLOAD) ? rem_q == LEN_WIDTH'(1) : 1'b0;
    xfer      = out_valid & out_ready;
    fifo_pop  = xfer ? grant_q : '0;
  end
endmodule

// File: tb/tb_router_out_arbiter.sv
// tb_router_out_arbiter: table-driven bench with behavioural show-ahead FIFOs per port.
module tb_router_out_arbiter;
  localparam int NP = 4;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst, out_ready, out_valid, out_sop, out_eop, busy;
  logic [NP-1:0] fifo_empty, fifo_pop, grant;
  logic [NP*DW-1:0] fifo_data;
  logic [DW-1:0] out_data;
  logic [15:0] pkt_cnt;
  router_out_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .LEN_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .grant(grant), .busy(busy), .pkt_cnt(pkt_cnt)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] mem [NP][64];
  logic [5:0] wp [NP] = '{default: '0};
  logic [5:0] rp [NP] = '{default: '0};
  int popcnt [NP] = '{default: 0};
  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i] = wp[i] == rp[i];
      fifo_data[i*DW +: DW] = (wp[i] == rp[i]) ? '0 : mem[i][rp[i]];
    end
  end
  always @(posedge clk)
    for (int i = 0; i < NP; i++)
      if (fifo_pop[i]) begin
        rp[i]     <= rp[i] + 6'd1;
        popcnt[i] <= popcnt[i] + 1;
      end
  task automatic push(input int p, input logic [DW-1:0] d);
    mem[p][wp[p]] = d;
    wp[p] = wp[p] + 6'd1;
  endtask
  task automatic flush();
    for (int i = 0; i < NP; i++) wp[i] = rp[i];
  endtask
  int total = 0, passed = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  typedef struct {
    logic ready, push; int pport; logic [7:0] pdata;
    logic [3:0] grant; logic valid; logic [7:0] data; logic sop, eop; logic [3:0] pop; logic busy;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(input logic rd, pu, input int pp, input logic [7:0] pd,
                              input logic [3:0] g, input logic v, input logic [7:0] d,
                              input logic s, e, input logic [3:0] po, input logic b);
    vec_t x;
    x.ready = rd; x.push = pu; x.pport = pp; x.pdata = pd;
    x.grant = g; x.valid = v; x.data = d; x.sop = s; x.eop = e; x.pop = po; x.busy = b;
    tbl.push_back(x);
  endfunction
  function automatic void idle(input logic rd);
    add(rd, 0, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 0);
  endfunction
  task automatic run(input int from, input int to, input string tag);
    for (int r = from; r < to; r++) begin
      out_ready = tbl[r].ready;
      if (tbl[r].push) push(tbl[r].pport, tbl[r].pdata);
      #1;
      chk($sformatf("%s[%0d].grant", tag, r - from), 32'(grant), 32'(tbl[r].grant));
      chk($sformatf("%s[%0d].valid", tag, r - from), 32'(out_valid), 32'(tbl[r].valid));
      chk($sformatf("%s[%0d].data", tag, r - from), 32'(out_data), 32'(tbl[r].data));
      chk($sformatf("%s[%0d].sop", tag, r - from), 32'(out_sop), 32'(tbl[r].sop));
      chk($sformatf("%s[%0d].eop", tag, r - from), 32'(out_eop), 32'(tbl[r].eop));
      chk($sformatf("%s[%0d].pop", tag, r - from), 32'(fifo_pop), 32'(tbl[r].pop));
      chk($sformatf("%s[%0d].busy", tag, r - from), 32'(busy), 32'(tbl[r].busy));
      @(negedge clk);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".grant"}, 32'(grant), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".valid"}, 32'(out_valid), 0);
    chk({tag, ".pop"}, 32'(fifo_pop), 0);
    chk({tag, ".sop"}, 32'(out_sop), 0);
    chk({tag, ".eop"}, 32'(out_eop), 0);
    chk({tag, ".data"}, 32'(out_data), 0);
    chk({tag, ".pkt_cnt"}, 32'(pkt_cnt), 0);
  endtask
  int s1, s2, s3, s4, s5, s6, base;
  initial begin
    s1 = tbl.size();
    idle(1);
    add(1, 0, 0, 0, 4'b0100, 1, 8'h03, 1, 0, 4'b0100, 1);
    add(1, 0, 0, 0, 4'b0100, 1, 8'hA1, 0, 0, 4'b0100, 1);
    add(1, 0, 0, 0, 4'b0100, 1, 8'hB2, 0, 0, 4'b0100, 1);
    add(1, 0, 0, 0, 4'b0100, 1, 8'hC3, 0, 1, 4'b0100, 1);
    idle(1);
    s2 = tbl.size();
    for (int p = 0; p < 5; p++) begin
      idle(1);
      add(1, 0, 0, 0, 4'(1 << (p % 4)), 1, 8'h00, 1, 1, 4'(1 << (p % 4)), 1);
    end
    idle(1);
    s3 = tbl.size();
    idle(1);
    add(1, 0, 0, 0, 4'b0010, 1, 8'h02, 1, 0, 4'b0010, 1);
    add(0, 0, 0, 0, 4'b0010, 1, 8'hD1, 0, 0, 4'b0000, 1);
    add(0, 0, 0, 0, 4'b0010, 1, 8'hD1, 0, 0, 4'b0000, 1);
    add(1, 0, 0, 0, 4'b0010, 1, 8'hD1, 0, 0, 4'b0010, 1);
    add(1, 0, 0, 0, 4'b0010, 1, 8'hD2, 0, 1, 4'b0010, 1);
    idle(1);
    s4 = tbl.size();
    idle(1);
    add(1, 0, 0, 0, 4'b0001, 1, 8'h02, 1, 0, 4'b0001, 1);
    add(1, 0, 0, 0, 4'b0001, 1, 8'hE1, 0, 0, 4'b0001, 1);
    add(1, 1, 3, 8'h00, 4'b0001, 0, 8'h00, 0, 1, 4'b0000, 1);
    add(1, 0, 0, 0, 4'b0001, 0, 8'h00, 0, 1, 4'b0000, 1);
    add(1, 1, 0, 8'hE2, 4'b0001, 1, 8'hE2, 0, 1, 4'b0001, 1);
    idle(1);
    add(1, 0, 0, 0, 4'b1000, 1, 8'h00, 1, 1, 4'b1000, 1);
    idle(1);
    s5 = tbl.size();
    idle(1);
    add(1, 0, 0, 0, 4'b0001, 1, 8'h04, 1, 0, 4'b0001, 1);
    add(1, 0, 0, 0, 4'b0001, 1, 8'hF1, 0, 0, 4'b0001, 1);
    s6 = tbl.size();
    rst = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    push(2, 8'h03); push(2, 8'hA1); push(2, 8'hB2); push(2, 8'hC3);
    run(s1, s2, "single");
    chk("single.pkt_cnt", 32'(pkt_cnt), 1);
    chk("single.pops", 32'(popcnt[2]), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(0, 8'h00); push(0, 8'h00); push(1, 8'h00); push(2, 8'h00); push(3, 8'h00);
    run(s2, s3, "rr");
    chk("rr.pkt_cnt", 32'(pkt_cnt), 5);
    base = popcnt[1];
    push(1, 8'h02); push(1, 8'hD1); push(1, 8'hD2);
    run(s3, s4, "stall");
    chk("stall.pops", 32'(popcnt[1] - base), 3);
    chk("stall.pkt_cnt", 32'(pkt_cnt), 6);
    push(0, 8'h02); push(0, 8'hE1);
    run(s4, s5, "starve");
    chk("starve.pkt_cnt", 32'(pkt_cnt), 8);
    push(0, 8'h04); push(0, 8'hF1); push(0, 8'hF2); push(0, 8'hF3); push(0, 8'hF4);
    run(s5, s6, "midrst");
    rst = 1'b1;
    #1 chk_zero("midrst.async");
    push(1, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst.idle_grant", 32'(grant), 0);
    @(negedge clk);
    #1 chk("midrst.first_grant", 32'(grant), 32'b0001);
    rst = 1'b1;
    flush();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    force dut.pkt_cnt_q = 16'hFFFF;
    #1 release dut.pkt_cnt_q;
    push(0, 8'h00);
    #1 chk("wrap.preset", 32'(pkt_cnt), 32'hFFFF);
    @(negedge clk);
    #1 chk("wrap.eop", 32'(out_eop & out_valid), 1);
    chk("wrap.before", 32'(pkt_cnt), 32'hFFFF);
    @(negedge clk);
    #1 chk("wrap.after", 32'(pkt_cnt), 0);
    chk("wrap.busy", 32'(busy), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
